instruction_prefetch: RTL and testbench
=======================================

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of instruction-pair entries in the prefetch FIFO (power of two, >=2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port redirect, input, 1 bit: taken-branch PC source from the memory stage.
REQ-005 The block SHALL have port redirect_pc, input, 11 bits: branch target byte address.
REQ-006 The block SHALL have port stall, input, 1 bit: the decode stage cannot accept a pair this cycle.
REQ-007 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-008 The block SHALL have port imem_addr, output, 11 bits: byte address of the requested pair.
REQ-009 The block SHALL have port imem_ack, input, 1 bit: read complete; imem_data is valid this cycle.
REQ-010 The block SHALL have port imem_data, input, 64 bits: [63:32] is instruction 1 and [31:0] is instruction 2.
REQ-011 The block SHALL have port pair_valid, output, 1 bit: the FIFO head is presented.
REQ-012 The block SHALL have ports instr1 and instr2, output, 32 bits each: the head pair.
REQ-013 The block SHALL have port pc_plus8, output, 11 bits: the head pair's address + 8, modulo 2048.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, FETCH and DROP.
REQ-015 In IDLE, imem_req SHALL be 0; the FSM SHALL go to FETCH next cycle when count < DEPTH and redirect=0.
REQ-016 In FETCH and DROP, imem_req SHALL be 1 and imem_addr SHALL equal the latched request address, held stable until imem_ack.
REQ-017 In FETCH on imem_ack with redirect=0, the block SHALL push {imem_data, addr+8} and set fetch_pc to fetch_pc+8, wrapping 2040 to 0.
REQ-018 After that push, the FSM SHALL stay in FETCH if the post-push count < DEPTH, else go to IDLE.
REQ-019 In FETCH, redirect with no imem_ack SHALL flush the FIFO, load fetch_pc and go to DROP.
REQ-020 In DROP, the data of the next imem_ack SHALL be discarded and the FSM SHALL go to IDLE.
REQ-021 A further redirect in DROP SHALL reload fetch_pc and flush, staying in DROP.
REQ-022 A redirect coinciding with imem_ack in FETCH SHALL discard the data, flush, load fetch_pc and go to IDLE.
REQ-023 A redirect in IDLE SHALL flush the FIFO and load fetch_pc.
REQ-024 On every redirect, fetch_pc SHALL be redirect_pc with bits [2:0] cleared.
REQ-025 pair_valid SHALL be 1 exactly when the FIFO is non-empty.
REQ-026 Pop SHALL occur when pair_valid=1 and stall=0 and redirect=0.
REQ-027 Latency SHALL be one cycle: imem_ack in cycle N makes the pair visible on the outputs in cycle N+1 when the FIFO was empty.
REQ-028 A simultaneous push and pop SHALL leave count unchanged; a push SHALL never occur when count=DEPTH.
REQ-029 Redirect SHALL take priority over push and pop, and pair_valid SHALL be 0 in the cycle after a redirect.
REQ-030 While stall=1, the outputs SHALL hold their values.

Reset
REQ-031 While reset=1, the block SHALL hold state IDLE, fetch_pc=0, FIFO empty, imem_req=0, imem_addr=0, pair_valid=0, instr1=0, instr2=0 and pc_plus8=0.
REQ-032 A reset asserted mid-request SHALL abandon the request without waiting for imem_ack; no stale ack SHALL be consumed after reset.

Structure
REQ-033 Package spu_fetch_pkg SHALL hold the state enum, PC_W=11, INSTR_W=32 and the pair struct {instr1, instr2, pc_plus8}.
REQ-034 The FIFO SHALL be sub-module fetch_fifo, with push/pop/flush, count, and pointers wrapping modulo DEPTH.

Verification
REQ-035 The bench SHALL cover: reset release with imem_ack one cycle after each request -> imem_addr 0, 8, 16, 24, then imem_req=0 with 4 entries, pair_valid=1, pc_plus8=8.
REQ-036 The bench SHALL cover: stall=1 for 5 cycles with the FIFO full -> no new imem_req and outputs held; stall=0 -> pc_plus8 sequence 8, 16, 24, 32.
REQ-037 The bench SHALL cover: redirect (redirect_pc=0x105) while imem_ack is delayed 3 cycles -> DROP, the old address is held, the acked data is discarded, and the next request has imem_addr=0x100.
REQ-038 The bench SHALL cover: redirect coinciding with imem_ack -> the data is not pushed, pair_valid=0 the next cycle, and the next imem_addr equals the target.
REQ-039 The bench SHALL cover: wrap-around with redirect_pc=2040 -> pairs at 2040 then 0, with pc_plus8 values 0 then 8.
REQ-040 The bench SHALL cover: reset asserted in FETCH before imem_ack -> all outputs 0 immediately and a later stray ack ignored.

Source files
------------

// File: rtl/spu_fetch_pkg.sv
// rtl/spu_fetch_pkg.sv - shared types, widths and PC helpers for the instruction prefetch block
package spu_fetch_pkg;

    localparam int PC_W    = 11;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr1;
        logic [INSTR_W-1:0] instr2;
        logic [PC_W-1:0]    pc_plus8;
    } pair_t;

    // Next pair address; the PC space is 2 KiB so the add wraps naturally
    function automatic logic [PC_W-1:0] pc_add8(input logic [PC_W-1:0] pc);
        return pc + PC_W'(8);
    endfunction

    // Fetches are pair-aligned, so branch targets drop their low three bits
    function automatic logic [PC_W-1:0] pair_align(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction-pair FIFO with push, pop and single-cycle flush
module fetch_fifo
    import spu_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  pair_t                    push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output pair_t                    head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pair_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_ok;
    logic               pop_ok;

    // Guard against overflow/underflow even if the caller misbehaves
    assign push_ok = push && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    // Storage is only read behind a valid count, so it carries no reset
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap modulo DEPTH; flush empties the queue in one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_prefetch.sv
// rtl/instruction_prefetch.sv - fetch FSM feeding instruction pairs into the prefetch FIFO
module instruction_prefetch
    import spu_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    input  logic                stall,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [63:0]         imem_data,
    output logic                pair_valid,
    output logic [INSTR_W-1:0]  instr1,
    output logic [INSTR_W-1:0]  instr2,
    output logic [PC_W-1:0]     pc_plus8
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]    req_addr_q, req_addr_d;
    logic               push;
    logic               pop;
    logic               flush;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   post_push_count;
    pair_t              head;
    pair_t              push_data;

    assign push_data       = '{instr1: imem_data[63:32], instr2: imem_data[31:0],
                               pc_plus8: pc_add8(req_addr_q)};
    assign pair_valid      = (count != '0);
    assign pop             = pair_valid && !stall && !redirect;
    assign post_push_count = count + CNT_W'(1) - CNT_W'(pop);

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = req_addr_q;
    assign instr1    = pair_valid ? head.instr1   : '0;
    assign instr2    = pair_valid ? head.instr2   : '0;
    assign pc_plus8  = pair_valid ? head.pc_plus8 : '0;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .flush    (flush),
        .count    (count),
        .head     (head)
    );

    // Next-state logic: redirect wins over everything, DROP swallows one in-flight ack
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = pair_align(redirect_pc);
                end else if (count < CNT_W'(DEPTH)) begin
                    state_d    = FETCH;
                    req_addr_d = fetch_pc_q;
                end
            end
            FETCH: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = pair_align(redirect_pc);
                    state_d    = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_add8(fetch_pc_q);
                    req_addr_d = pc_add8(fetch_pc_q);
                    state_d    = (post_push_count < CNT_W'(DEPTH)) ? FETCH : IDLE;
                end
            end
            DROP: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = pair_align(redirect_pc);
                end
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, fetch PC and the address held on the memory port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch.sv
// tb/tb_instruction_prefetch.sv - self-checking bench for instruction_prefetch
module tb_instruction_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [10:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [10:0] imem_addr;
    logic        imem_ack;
    logic [63:0] imem_data;
    logic        pair_valid;
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic [10:0] pc_plus8;

    always #5 clk = ~clk;

    instruction_prefetch #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .pair_valid (pair_valid),
        .instr1     (instr1),
        .instr2     (instr2),
        .pc_plus8   (pc_plus8)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of pairs plus the one outstanding memory request
    typedef struct {
        logic [31:0] i1;
        logic [31:0] i2;
        logic [10:0] pc8;
    } mpair_t;

    mpair_t      mq[$];
    mpair_t      m_new;
    bit          m_req  = 1'b0;
    bit          m_drop = 1'b0;
    logic [10:0] m_addr = '0;
    logic [10:0] m_pc   = '0;
    int          m_pre;
    bit          m_pop;

    task automatic model_step();
        if (reset) begin
            mq.delete();
            m_req  = 1'b0;
            m_drop = 1'b0;
            m_addr = '0;
            m_pc   = '0;
        end else begin
            m_pre = mq.size();
            m_pop = (m_pre > 0) && !stall && !redirect;
            if (redirect) begin
                mq.delete();
                m_pc = {redirect_pc[10:3], 3'b000};
                if (m_req) begin
                    if (imem_ack) begin
                        m_req  = 1'b0;
                        m_drop = 1'b0;
                    end else begin
                        m_drop = 1'b1;
                    end
                end
            end else begin
                if (m_pop) mq.delete(0);
                if (!m_req) begin
                    if (m_pre < DEPTH) begin
                        m_req  = 1'b1;
                        m_addr = m_pc;
                    end
                end else if (imem_ack) begin
                    if (m_drop) begin
                        m_req  = 1'b0;
                        m_drop = 1'b0;
                    end else begin
                        m_new.i1  = imem_data[63:32];
                        m_new.i2  = imem_data[31:0];
                        m_new.pc8 = m_addr + 11'd8;
                        mq.push_back(m_new);
                        m_pc = m_addr + 11'd8;
                        if (mq.size() >= DEPTH) m_req = 1'b0;
                        else m_addr = m_pc;
                    end
                end
            end
        end
    endtask

    always @(posedge clk or posedge reset) model_step();

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        chk("cyc_imem_req", imem_req, m_req);
        if (m_req) chk("cyc_imem_addr", imem_addr, m_addr);
        chk("cyc_pair_valid", pair_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("cyc_instr1", instr1, mq[0].i1);
            chk("cyc_instr2", instr2, mq[0].i2);
            chk("cyc_pc_plus8", pc_plus8, mq[0].pc8);
        end
    end

    // Memory responder state
    bit          auto_mem = 1'b0;
    int          wait_cnt = 0;
    int          mem_lat  = 0;
    int          min_lat  = 0;
    int          max_lat  = 0;
    logic [10:0] acked[$];
    logic [63:0] acked_data[$];

    task automatic cycle();
        @(posedge clk);
        #1;
        if (auto_mem) begin
            if (imem_req && !reset) begin
                if (wait_cnt >= mem_lat) begin
                    imem_ack  = 1'b1;
                    imem_data = {$urandom, $urandom};
                    acked.push_back(imem_addr);
                    acked_data.push_back(imem_data);
                    wait_cnt  = 0;
                    mem_lat   = $urandom_range(max_lat, min_lat);
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        chk(name, imem_req, 1'b1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_imem_req"}, imem_req, 1'b0);
        chk({tag, "_imem_addr"}, imem_addr, 11'd0);
        chk({tag, "_pair_valid"}, pair_valid, 1'b0);
        chk({tag, "_instr1"}, instr1, 32'd0);
        chk({tag, "_instr2"}, instr2, 32'd0);
        chk({tag, "_pc_plus8"}, pc_plus8, 11'd0);
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b1;
        imem_ack    = 1'b0;
        imem_data   = '0;
        cycle();
        cycle();
        chk_zero_outputs("reset");

        // Fill from reset with single-cycle memory
        reset    = 1'b0;
        auto_mem = 1'b1;
        min_lat  = 1;
        max_lat  = 1;
        mem_lat  = 1;
        wait_cnt = 0;
        acked.delete();
        acked_data.delete();
        for (int i = 0; i < 40 && acked.size() < 4; i++) cycle();
        cycle();
        chk("fill_ack_count", acked.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("fill_addr%0d", i), (i < acked.size()) ? acked[i] : 11'h7ff, 11'(8 * i));
        chk("fill_req_off", imem_req, 1'b0);
        chk("fill_valid", pair_valid, 1'b1);
        chk("fill_pc_plus8", pc_plus8, 11'd8);
        chk("fill_model_count", mq.size(), 4);

        // Full FIFO under stall: no requests, head held
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_req", imem_req, 1'b0);
            chk("stall_pc_plus8", pc_plus8, 11'd8);
            chk("stall_instr1", instr1, acked_data.size() > 0 ? acked_data[0][63:32] : 32'hx);
            chk("stall_instr2", instr2, acked_data.size() > 0 ? acked_data[0][31:0] : 32'hx);
        end
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_pc_plus8_%0d", k), pc_plus8, 11'(8 * (k + 1)));
            cycle();
        end
        stall = 1'b1;

        // Redirect while the ack is delayed: old address held, data dropped
        auto_mem = 1'b0;
        imem_ack = 1'b0;
        reset    = 1'b1;
        cycle();
        reset = 1'b0;
        wait_req("drop_first_req");
        chk("drop_first_addr", imem_addr, 11'd0);
        redirect    = 1'b1;
        redirect_pc = 11'h105;
        cycle();
        redirect = 1'b0;
        chk("drop_req", imem_req, 1'b1);
        chk("drop_addr_hold0", imem_addr, 11'd0);
        chk("drop_valid", pair_valid, 1'b0);
        cycle();
        chk("drop_addr_hold1", imem_addr, 11'd0);
        cycle();
        chk("drop_addr_hold2", imem_addr, 11'd0);
        imem_ack  = 1'b1;
        imem_data = 64'hDEAD_BEEF_0BAD_F00D;
        cycle();
        imem_ack = 1'b0;
        chk("drop_done_req", imem_req, 1'b0);
        chk("drop_discard_valid", pair_valid, 1'b0);
        cycle();
        chk("drop_new_req", imem_req, 1'b1);
        chk("drop_new_addr", imem_addr, 11'h100);

        // Redirect coinciding with ack
        imem_ack  = 1'b1;
        imem_data = 64'h1111_2222_3333_4444;
        cycle();
        imem_ack = 1'b0;
        chk("coin_pre_valid", pair_valid, 1'b1);
        chk("coin_pre_pc_plus8", pc_plus8, 11'h108);
        chk("coin_pre_instr1", instr1, 32'h1111_2222);
        chk("coin_pre_addr", imem_addr, 11'h108);
        redirect    = 1'b1;
        redirect_pc = 11'h2F3;
        imem_ack    = 1'b1;
        imem_data   = 64'h5555_6666_7777_8888;
        cycle();
        redirect = 1'b0;
        imem_ack = 1'b0;
        chk("coin_flush_valid", pair_valid, 1'b0);
        chk("coin_idle_req", imem_req, 1'b0);
        cycle();
        chk("coin_next_req", imem_req, 1'b1);
        chk("coin_next_addr", imem_addr, 11'h2F0);

        // Wrap-around at the top of the PC space
        reset = 1'b1;
        cycle();
        cycle();
        reset       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 11'd2040;
        cycle();
        redirect = 1'b0;
        auto_mem = 1'b1;
        min_lat  = 0;
        max_lat  = 0;
        mem_lat  = 0;
        wait_cnt = 0;
        acked.delete();
        acked_data.delete();
        for (int i = 0; i < 20 && acked.size() < 2; i++) cycle();
        auto_mem = 1'b0;
        cycle();
        imem_ack = 1'b0;
        chk("wrap_ack_count", acked.size(), 2);
        chk("wrap_addr0", acked.size() > 0 ? acked[0] : 11'h7ff, 11'd2040);
        chk("wrap_addr1", acked.size() > 1 ? acked[1] : 11'h7ff, 11'd0);
        chk("wrap_valid", pair_valid, 1'b1);
        chk("wrap_pc_plus8_a", pc_plus8, 11'd0);
        stall = 1'b0;
        cycle();
        stall = 1'b1;
        chk("wrap_pc_plus8_b", pc_plus8, 11'd8);

        // Reset mid-request, then a stray ack
        wait_req("rst_req");
        chk("rst_valid_before", pair_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_zero_outputs("rst_async");
        cycle();
        cycle();
        reset     = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 64'hBAD0_BAD0_BAD0_BAD0;
        cycle();
        imem_ack = 1'b0;
        chk("stray_valid", pair_valid, 1'b0);
        chk("stray_req", imem_req, 1'b1);
        chk("stray_addr", imem_addr, 11'd0);
        cycle();
        chk("stray_valid_later", pair_valid, 1'b0);

        // Randomized traffic against the model
        reset = 1'b1;
        cycle();
        reset    = 1'b0;
        auto_mem = 1'b1;
        min_lat  = 0;
        max_lat  = 3;
        mem_lat  = 2;
        wait_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            stall       = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 11'($urandom);
        end
        redirect = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
